// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared definitions for the data memory controller slice.
//   - request op encodings (OP_RD_W, OP_WR_B, OP_WR_W, OP_RD_B)
//   - controller FSM state type
//   - boot image bytes used by the optional DATA_MEM_PRELOAD_EN sequencer
package data_mem_pkg;

   localparam logic [1:0] OP_RD_W = 2'b00;
   localparam logic [1:0] OP_WR_B = 2'b01;
   localparam logic [1:0] OP_WR_W = 2'b10;
   localparam logic [1:0] OP_RD_B = 2'b11;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int unsigned BOOT_LEN = 10;
   // Byte 0 is the leftmost byte.
   localparam logic [8*BOOT_LEN-1:0] BOOT_IMG = 80'h2BCD_0000_1234_DEAD_BEEF;

   function automatic logic [7:0] boot_byte(input int unsigned i);
      if (i < BOOT_LEN)
         return BOOT_IMG[8*(BOOT_LEN-1-i) +: 8];
      else
         return 8'h00;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x 8 byte storage, big-endian lane mapping.
//   clk      in   clock
//   addr     in   base byte address; lane j maps to byte addr+j
//   wr_be    in   per-lane write enable (lane 0 = MSB byte of wr_data)
//   wr_data  in   write data, lane j at bits [DATA_W-1-8j -: 8]
//   rd_data  out  combinational read at addr; lanes past DEPTH read 0
// Storage is never reset.
module data_mem_array #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 16
) (
   input  logic                  clk,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W-1:0]     rd_data
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [ADDR_W:0] lane_addr [BYTES];

   always_comb begin
      for (int unsigned j = 0; j < BYTES; j++)
         lane_addr[j] = {1'b0, addr} + (ADDR_W+1)'(j);
   end

   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < BYTES; j++) begin
         if (wr_be[j] && (lane_addr[j] < DEPTH_X))
            mem[IDX_W'(lane_addr[j])] <= wr_data[DATA_W-1-8*j -: 8];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned j = 0; j < BYTES; j++) begin
         if (lane_addr[j] < DEPTH_X)
            rd_data[DATA_W-1-8*j -: 8] = mem[IDX_W'(lane_addr[j])];
      end
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable big-endian data memory with valid/ready
// request and response channels and programmable read latency.
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_ready, req_op, req_addr, req_wdata   request channel
//   resp_valid/resp_ready, resp_rdata, resp_err        response channel
//   init_done     memory usable
// Optional feature: DATA_MEM_PRELOAD_EN adds a reset-time INIT walk that
// writes the boot image (then zeros) into every byte before accepting work.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              init_done
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

`ifdef DATA_MEM_PRELOAD_EN
   localparam state_t RST_STATE = ST_INIT;
   localparam logic   RST_READY = 1'b0;
`else
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_READY = 1'b1;
`endif

   state_t            state, state_n;
   logic [1:0]        cnt, cnt_n;

   logic              is_word, is_write, fault, accept;
   logic [ADDR_W+1:0] end_addr;
   logic [DATA_W-1:0] acc_rdata;

   logic [ADDR_W-1:0] arr_addr;
   logic [BYTES-1:0]  arr_be;
   logic [DATA_W-1:0] arr_wdata, arr_rdata;

`ifdef DATA_MEM_PRELOAD_EN
   logic [ADDR_W-1:0] init_idx;
`endif

   data_mem_array #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .addr    (arr_addr),
      .wr_be   (arr_be),
      .wr_data (arr_wdata),
      .rd_data (arr_rdata)
   );

   // Request decode and fault checks.
   always_comb begin
      is_word  = (req_op == OP_RD_W) || (req_op == OP_WR_W);
      is_write = (req_op == OP_WR_B) || (req_op == OP_WR_W);
      end_addr = {2'b00, req_addr} + (is_word ? (ADDR_W+2)'(BYTES) : (ADDR_W+2)'(1));
      fault    = (is_word && ((req_addr % ADDR_W'(BYTES)) != '0)) || (end_addr > DEPTH_X);
      accept   = req_valid && req_ready && !rst;
      acc_rdata = '0;
      if (!fault && !is_write) begin
         if (req_op == OP_RD_B)
            acc_rdata = {{(DATA_W-8){1'b0}}, arr_rdata[DATA_W-1 -: 8]};
         else
            acc_rdata = arr_rdata;
      end
   end

   // Next state and array port control.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      arr_addr  = req_addr;
      arr_be    = '0;
      arr_wdata = is_word ? req_wdata : {req_wdata[7:0], {(DATA_W-8){1'b0}}};
      case (state)
`ifdef DATA_MEM_PRELOAD_EN
         ST_INIT: begin
            arr_addr  = init_idx;
            arr_be    = BYTES'(1);
            arr_wdata = {boot_byte(32'(init_idx)), {(DATA_W-8){1'b0}}};
            if (init_idx == ADDR_W'(DEPTH-1))
               state_n = ST_IDLE;
         end
`endif
         ST_IDLE: begin
            if (accept) begin
               if (is_write && !fault)
                  arr_be = is_word ? '1 : BYTES'(1);
               if (LATENCY == 1) begin
                  state_n = ST_RESP;
                  cnt_n   = '0;
               end else begin
                  state_n = ST_WAIT;
                  cnt_n   = 2'(LATENCY-1);
               end
            end
         end
         ST_WAIT: begin
            cnt_n = cnt - 2'd1;
            if (cnt == 2'd1)
               state_n = ST_RESP;
         end
         ST_RESP: begin
            if (resp_valid && resp_ready)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      if (rst)
         arr_be = '0;
   end

   // resp_valid trails entry into RESP by one edge, so the accept-to-valid
   // distance equals LATENCY for every setting including LATENCY=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RST_STATE;
         cnt        <= '0;
         req_ready  <= RST_READY;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         req_ready <= (state_n == ST_IDLE);
         if (state == ST_RESP)
            resp_valid <= !(resp_valid && resp_ready);
         else
            resp_valid <= 1'b0;
         if (accept) begin
            resp_rdata <= acc_rdata;
            resp_err   <= fault;
         end
      end
   end

`ifdef DATA_MEM_PRELOAD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         init_idx  <= '0;
         init_done <= 1'b0;
      end else begin
         if (state == ST_INIT)
            init_idx <= init_idx + 1'b1;
         init_done <= (state_n != ST_INIT);
      end
   end
`else
   assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
// (DATA_W=32, LATENCY=3, DEPTH=256). Works with or without
// DATA_MEM_PRELOAD_EN defined.
module tb_data_mem_ctrl;
   import data_mem_pkg::*;

   localparam int unsigned AW  = 16;
   localparam int unsigned DEP = 256;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 3;
   localparam int unsigned NB  = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic          init_done;

   data_mem_ctrl #(
      .ADDR_W  (AW),
      .DEPTH   (DEP),
      .DATA_W  (DW),
      .LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            acc;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mm [DEP];
   logic [7:0] boot [10] = '{8'h2B, 8'hCD, 8'h00, 8'h00, 8'h12,
                             8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
   bit busy = 0, init_ok = 0, prev_valid = 0;
   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_wordop(input logic [1:0] op);
      return (op == OP_RD_W) || (op == OP_WR_W);
   endfunction

   function automatic bit faults(input logic [1:0] op, input logic [AW-1:0] addr);
      int unsigned a = addr;
      int unsigned sz = is_wordop(op) ? NB : 1;
      return (is_wordop(op) && (a % NB != 0)) || (a + sz > DEP);
   endfunction

   function automatic exp_t model(input logic [1:0] op, input logic [AW-1:0] addr);
      exp_t e;
      int unsigned a = addr;
      e.err = faults(op, addr);
      e.rdata = '0;
      e.acc = 0;
      if (!e.err && op == OP_RD_W)
         for (int unsigned i = 0; i < NB; i++) e.rdata = (e.rdata << 8) | DW'(mm[a+i]);
      if (!e.err && op == OP_RD_B)
         e.rdata = DW'(mm[a]);
      return e;
   endfunction

   task automatic model_write(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      int unsigned a = addr;
      if (op == OP_WR_W)
         for (int unsigned i = 0; i < NB; i++) mm[a+i] = 8'(wd >> (8*(NB-1-i)));
      else
         mm[a] = wd[7:0];
   endtask

   task automatic compare();
      if (rst) begin
         prev_valid = 0;
         return;
      end
      if (resp_valid) begin
         if (q.size() == 0)
            chk("spurious_resp_valid", 1, 0);
         else begin
            chk("resp_rdata", resp_rdata, q[0].rdata);
            chk("resp_err", resp_err, q[0].err);
            if (!prev_valid) chk("resp_latency", cyc - q[0].acc, LAT);
         end
         chk("req_ready_during_resp", req_ready, 0);
      end else if (init_ok)
         chk("req_ready", req_ready, !busy);
      prev_valid = resp_valid;
   endtask

   task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int hold, input bit abort,
                         output logic [DW-1:0] rd, output logic er);
      exp_t e;
      int n;
      rd = '0;
      er = 1'b0;
      @(posedge clk); #2;
      n = 0;
      while (!req_ready && n < int'(DEP) + 20) begin
         @(posedge clk); #2;
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 0, 1);
         return;
      end
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      e = model(op, addr);
      @(posedge clk); #2;
      req_valid = 1'b0;
      e.acc = cyc;
      q.push_back(e);
      busy = 1;
      if ((op == OP_WR_B || op == OP_WR_W) && !e.err) model_write(op, addr, wd);
      if (abort) return;
      n = 0;
      while (!resp_valid && n < int'(LAT) + 5) begin
         @(posedge clk); #2;
         n++;
      end
      if (!resp_valid) begin
         chk("resp_valid_timeout", 0, 1);
         q.delete();
         busy = 0;
         return;
      end
      repeat (hold) begin @(posedge clk); #2; end
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #2;
      resp_ready = 1'b0;
      q.delete(0);
      busy = 0;
   endtask

   task automatic do_reset();
      int c0, n;
      init_ok = 0;
      @(posedge clk); #2;
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      q.delete();
      busy = 0;
      c0 = cyc;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
`ifdef DATA_MEM_PRELOAD_EN
      chk("rst_req_ready", req_ready, 0);
      chk("rst_init_done", init_done, 0);
      n = 0;
      while (!init_done && n < int'(DEP) + 10) begin
         @(posedge clk); #2;
         n++;
      end
      chk("init_done_edges", cyc - c0, DEP);
      chk("init_req_ready", req_ready, 1);
      for (int unsigned i = 0; i < DEP; i++) mm[i] = (i < 10) ? boot[i] : 8'h00;
`else
      n = c0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_init_done", init_done, 1);
`endif
      init_ok = 1;
   endtask

   logic [DW-1:0] rd;
   logic          er;
   logic [7:0]    exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         forever begin
            @(negedge clk);
            compare();
         end
      join_none

      do_reset();

`ifdef DATA_MEM_PRELOAD_EN
      do_req(OP_RD_W, 16'h0000, '0, 0, 0, rd, er); chk("boot_word0", rd, 32'h2BCD0000);
      do_req(OP_RD_W, 16'h0008, '0, 0, 0, rd, er); chk("boot_word8", rd, 32'hBEEF0000);
      do_req(OP_RD_B, 16'h0005, '0, 0, 0, rd, er); chk("boot_byte5", rd, 32'h00000034);
`endif

      do_req(OP_WR_W, 16'h0010, 32'hA55AC33C, 0, 0, rd, er);
      chk("wr_ack_rdata", rd, 0);
      chk("wr_ack_err", er, 0);
      do_req(OP_RD_W, 16'h0010, '0, 5, 0, rd, er);
      chk("rd_word_10_held", rd, 32'hA55AC33C);
      do_req(OP_RD_B, 16'h0011, '0, 0, 0, rd, er);
      chk("rd_byte_11", rd, 32'h0000005A);
      do_req(OP_WR_B, 16'h0011, 32'hFFFFFFE7, 0, 0, rd, er);
      do_req(OP_RD_W, 16'h0010, '0, 0, 0, rd, er);
      chk("rd_word_after_byte_wr", rd, 32'hA5E7C33C);

      do_req(OP_WR_W, 16'h0004, 32'h11223344, 0, 0, rd, er);
      for (int i = 0; i < 4; i++) begin
         do_req(OP_RD_B, AW'(4 + i), '0, (i == 2) ? 3 : 0, 0, rd, er);
         chk("rd_byte_be", rd, DW'(exp_b[i]));
      end

      do_req(OP_RD_W, 16'h0003, '0, 0, 0, rd, er);
      chk("misalign_err", er, 1);
      chk("misalign_rdata", rd, 0);

      do_req(OP_WR_B, 16'h0000, 32'h00000077, 0, 0, rd, er);
      do_req(OP_WR_W, AW'(DEP-4), 32'hCAFEF00D, 0, 0, rd, er);
      chk("top_word_ok", er, 0);
      do_req(OP_WR_W, AW'(DEP-1), 32'h99999999, 0, 0, rd, er);
      chk("wr_oob_err", er, 1);
      chk("wr_oob_rdata", rd, 0);
      do_req(OP_RD_B, AW'(DEP-1), '0, 0, 0, rd, er);
      chk("last_byte_kept", rd, 32'h0000000D);
      chk("last_byte_err", er, 0);
      do_req(OP_RD_B, 16'h0000, '0, 0, 0, rd, er);
      chk("byte0_kept", rd, 32'h00000077);
      do_req(OP_RD_W, AW'(DEP), '0, 0, 0, rd, er);
      chk("rd_word_past_end", er, 1);
      do_req(OP_RD_B, AW'(DEP), '0, 0, 0, rd, er);
      chk("rd_byte_past_end", er, 1);
      do_req(OP_WR_W, AW'(DEP-2), 32'h12345678, 0, 0, rd, er);
      chk("wr_misalign_err", er, 1);

      // Abort a write in WAIT with reset; the write itself already landed.
      do_req(OP_WR_W, 16'h0020, 32'h5EED1234, 0, 1, rd, er);
      do_reset();
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         @(posedge clk); #2;
         chk("abort_no_resp", resp_valid, 0);
      end
      do_req(OP_RD_W, 16'h0020, '0, 0, 0, rd, er);
`ifdef DATA_MEM_PRELOAD_EN
      chk("after_abort_word", rd, 32'h00000000);
`else
      chk("after_abort_word", rd, 32'h5EED1234);
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
